ram_dp_param: RTL and testbench
===============================

# ram_dp_param

Parametrised simple-dual-port RAM: one write port with byte enables and one read port, a configurable read pipeline depth, a selectable read-during-write policy and a hardware clear sequencer. It is the next-generation memory block for the same environment. Bench interfaces bind to it the same way they bind to the current fixed-size RAM, with the added `w_be`, `r_valid`, `clr` and `busy` signals.

## Interface
Parameters:
- DATA_W, 16: data width in bits; must be a multiple of 8.
- ADDR_W, 4: address width in bits.
- DEPTH, 16: number of words; must be ≤ 2**ADDR_W.
- RD_LAT, 1: read latency in cycles; legal values are 1 and 2.
- RDW_MODE, 0: same-address read-during-write policy. 0 = read-old (return prior contents); 1 = write-first (return the merged new word).
- CLR_ON_RST, 1: when 1, a clear sequence starts automatically after reset.

Ports:
- clk, input, 1: single clock; all logic is on the rising edge.
- rst, input, 1: asynchronous, active-high reset.
- enb, input, 1: global enable; when low, no read or write is accepted.
- wr, input, 1: write request.
- w_addr, input, ADDR_W: write address.
- w_data, input, DATA_W: write data.
- w_be, input, DATA_W/8: byte enables. Bit i enables byte lane [8i+7:8i].
- rd, input, 1: read request.
- r_addr, input, ADDR_W: read address.
- r_data, output, DATA_W: read data; holds its last value when not updated.
- r_valid, output, 1: one-cycle pulse marking new r_data.
- clr, input, 1: request to zero the whole array.
- busy, output, 1: high while a clear is in progress; requests are ignored while it is high.

## Operation
- Reset values: r_data = 0, r_valid = 0, read pipeline flushed, clear counter = 0. FSM goes to CLEAR with busy = 1 if CLR_ON_RST = 1, otherwise IDLE with busy = 0. Array contents are not reset asynchronously; only the clear sequence zeroes them.
- FSM states:
  - IDLE: requests are accepted. clr = 1 moves the FSM to CLEAR at the next edge.
  - CLEAR: one word is zeroed per edge, mem[cnt] = 0 and cnt increments. On the edge that writes DEPTH-1, the FSM returns to IDLE and cnt returns to 0.
- Write acceptance: a write occurs when enb & wr & !busy & !clr. Only enabled byte lanes are updated. A write with w_be = 0 is a no-op.
- Read acceptance: a read occurs when enb & rd & !busy & !clr. Each accepted read produces exactly one r_valid pulse.
- Same-cycle clr in IDLE: clr takes priority, and any read or write presented in that cycle is dropped.
- clr while busy: ignored; the running clear is not restarted.
- Reads already in the pipeline when clr is accepted complete normally with pre-clear data.
- Out-of-range addresses (addr ≥ DEPTH): the write is discarded. The read is still accepted and returns 0 with r_valid.
- Simultaneous read and write to the same address:
  - RDW_MODE = 0 returns the old word.
  - RDW_MODE = 1 returns the old word with the enabled lanes replaced by w_data.
  - Different addresses never interact.
- Reset asserted mid-operation: the clear sequence (if active) aborts, the pipeline and r_valid clear immediately, and the clear sequence restarts from address 0 after release if CLR_ON_RST = 1.

## Timing
- Read latency:
  - RD_LAT = 1: a read accepted at edge N drives r_data and r_valid after edge N, valid for cycle N+1.
  - RD_LAT = 2: the result appears after edge N+1.
- Throughput: one read and one write per cycle, back-to-back, with no bubbles.
- Write visibility: a write accepted at edge N is visible to a read accepted at edge N+1 or later, regardless of RDW_MODE.
- busy:
  - Registered; it reflects FSM state only.
  - After reset release, or after clr is sampled at edge K, busy stays high for exactly DEPTH cycles.
  - For a clr sampled at edge K, busy rises after edge K and falls after edge K+DEPTH.
- First access after clear: the first accepted request is at the edge after busy falls.

## Test plan
Scenarios use DATA_W = 16, ADDR_W = 4, DEPTH = 16.
- Reset clear: CLR_ON_RST = 1. Release rst and count cycles → busy is high for 16 cycles. Then reading all 16 addresses returns 0x0000, each with one r_valid pulse.
- Byte enables: write 0xABCD with w_be = 2'b11 to addr 3, then write 0x1234 with w_be = 2'b01 to addr 3, then read addr 3 → 0xAB34.
- Read-during-write on addr 5, which holds 0x1111; write 0x2222 with w_be = 2'b11 while reading addr 5 in the same cycle → 0x1111 with RDW_MODE = 0, 0x2222 with RDW_MODE = 1.
- Read latency and throughput: back-to-back reads of addrs 0–7, each pre-loaded with value addr*0x0101, RD_LAT = 2 → first r_valid two cycles after the first read. r_valid then stays high for 8 consecutive cycles with data 0x0000, 0x0101, …, 0x0707 in order.
- Soft clear collision: in IDLE, assert clr together with a write of 0xFFFF to addr 2 → the write is dropped and busy is high for 16 cycles. A subsequent read of addr 2 returns 0x0000. A second clr during busy does not extend busy.
- Reset mid-clear and out-of-range: assert rst at clear cycle 7 → r_valid = 0 and busy = 1 immediately, and the clear restarts at addr 0 for a full 16 cycles. With DEPTH = 12: a write to addr 13 is ignored, and a read of addr 13 returns 0x0000 with r_valid.

Source files
------------

// File: rtl/ram_dp_param.sv
// ram_dp_param: simple-dual-port RAM with byte-enabled writes, a 1- or 2-stage
// read pipeline, selectable same-address read-during-write behaviour and a
// hardware clear sequencer that zeroes one word per clock.
module ram_dp_param #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 4,
  parameter int DEPTH      = 16,
  parameter int RD_LAT     = 1,
  parameter int RDW_MODE   = 0,
  parameter int CLR_ON_RST = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enb,
  input  logic                wr,
  input  logic [ADDR_W-1:0]   w_addr,
  input  logic [DATA_W-1:0]   w_data,
  input  logic [DATA_W/8-1:0] w_be,
  input  logic                rd,
  input  logic [ADDR_W-1:0]   r_addr,
  output logic [DATA_W-1:0]   r_data,
  output logic                r_valid,
  input  logic                clr,
  output logic                busy
);

  localparam int NB = DATA_W / 8;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;
  localparam logic [0:0] ST_RESET = (CLR_ON_RST != 0) ? ST_CLEAR : ST_IDLE;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  logic              p1Valid_q;
  logic [DATA_W-1:0] p1Data_q;
  logic              rValid_q;
  logic [DATA_W-1:0] rData_q;

  logic              wrAcc, rdAcc, wInRange, rInRange, wrDo;
  logic [DATA_W-1:0] oldWord, rdWord;

  // busy is simply the registered FSM state, so it never glitches on inputs
  assign busy    = (state_q == ST_CLEAR);
  assign r_valid = rValid_q;
  assign r_data  = rData_q;

  // a pending clr steals the cycle, so reads and writes beside it are dropped
  assign wrAcc    = enb & wr & ~busy & ~clr;
  assign rdAcc    = enb & rd & ~busy & ~clr;
  assign wInRange = ({1'b0, w_addr} < DEPTH_X);
  assign rInRange = ({1'b0, r_addr} < DEPTH_X);
  assign wrDo     = wrAcc & wInRange;

  // clear sequencer: walk cnt from 0 to DEPTH-1, then fall back to IDLE
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (clr) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      ST_CLEAR: begin
        if (cnt_q == LAST_ADDR) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM and clear counter registers; reset restarts any clear from address 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RESET;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // storage array: clearing owns the write port while busy, otherwise lane writes
  always_ff @(posedge clk) begin
    if (busy) begin
      mem[cnt_q] <= '0;
    end else if (wrDo) begin
      for (int i = 0; i < NB; i++) begin
        if (w_be[i]) mem[w_addr][8*i +: 8] <= w_data[8*i +: 8];
      end
    end
  end

  // read word, with optional write-first bypass of the lanes written this cycle
  always_comb begin
    oldWord = rInRange ? mem[r_addr] : '0;
    rdWord  = oldWord;
    if ((RDW_MODE == 1) && wrDo && (w_addr == r_addr)) begin
      for (int i = 0; i < NB; i++) begin
        if (w_be[i]) rdWord[8*i +: 8] = w_data[8*i +: 8];
      end
    end
  end

  // read pipeline: data is captured at acceptance, so later clears cannot alter it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p1Valid_q <= 1'b0;
      p1Data_q  <= '0;
      rValid_q  <= 1'b0;
      rData_q   <= '0;
    end else begin
      p1Valid_q <= rdAcc;
      if (rdAcc) p1Data_q <= rdWord;
      if (RD_LAT == 2) begin
        rValid_q <= p1Valid_q;
        if (p1Valid_q) rData_q <= p1Data_q;
      end else begin
        rValid_q <= rdAcc;
        if (rdAcc) rData_q <= rdWord;
      end
    end
  end

endmodule

// File: tb/tb_ram_dp_param.sv
// tb_ram_dp_param: directed scenarios against three RAM configurations with a
// per-instance scoreboard of expected read data.
//   A: RD_LAT=1, RDW_MODE=0, DEPTH=16, clear on reset
//   B: RD_LAT=2, RDW_MODE=1, DEPTH=16, clear on reset (shares A's inputs)
//   C: RD_LAT=1, RDW_MODE=0, DEPTH=12, no clear on reset (own inputs)
module tb_ram_dp_param;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic        enb = 1'b1, wr = 1'b0, rd = 1'b0, clr = 1'b0;
  logic [3:0]  wAddr = '0, rAddr = '0;
  logic [15:0] wData = '0;
  logic [1:0]  wBe = '0;

  logic        cEnb = 1'b1, cWr = 1'b0, cRd = 1'b0, cClr = 1'b0;
  logic [3:0]  cWAddr = '0, cRAddr = '0;
  logic [15:0] cWData = '0;
  logic [1:0]  cWBe = '0;

  logic [15:0] rDataA, rDataB, rDataC;
  logic        rValidA, rValidB, rValidC;
  logic        busyA, busyB, busyC;

  logic [15:0] qA[$];
  logic [15:0] qB[$];
  logic [15:0] qC[$];

  int nCompared = 0;
  int nMismatch = 0;

  ram_dp_param #(.DATA_W(16), .ADDR_W(4), .DEPTH(16), .RD_LAT(1), .RDW_MODE(0), .CLR_ON_RST(1)) dutA (
    .clk(clk), .rst(rst), .enb(enb), .wr(wr), .w_addr(wAddr), .w_data(wData), .w_be(wBe),
    .rd(rd), .r_addr(rAddr), .r_data(rDataA), .r_valid(rValidA), .clr(clr), .busy(busyA));

  ram_dp_param #(.DATA_W(16), .ADDR_W(4), .DEPTH(16), .RD_LAT(2), .RDW_MODE(1), .CLR_ON_RST(1)) dutB (
    .clk(clk), .rst(rst), .enb(enb), .wr(wr), .w_addr(wAddr), .w_data(wData), .w_be(wBe),
    .rd(rd), .r_addr(rAddr), .r_data(rDataB), .r_valid(rValidB), .clr(clr), .busy(busyB));

  ram_dp_param #(.DATA_W(16), .ADDR_W(4), .DEPTH(12), .RD_LAT(1), .RDW_MODE(0), .CLR_ON_RST(0)) dutC (
    .clk(clk), .rst(rst), .enb(cEnb), .wr(cWr), .w_addr(cWAddr), .w_data(cWData), .w_be(cWBe),
    .rd(cRd), .r_addr(cRAddr), .r_data(rDataC), .r_valid(rValidC), .clr(cClr), .busy(busyC));

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    assert (obs === exp) else begin
      nMismatch++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // drive shared inputs of A/B for one cycle; returns at the following negedge
  task automatic applyStimulus(input logic w, input logic [3:0] wa, input logic [15:0] wd,
                               input logic [1:0] be, input logic r, input logic [3:0] ra,
                               input logic c);
    wr = w; wAddr = wa; wData = wd; wBe = be; rd = r; rAddr = ra; clr = c;
    @(negedge clk);
  endtask

  task automatic applyStimulusC(input logic w, input logic [3:0] wa, input logic [15:0] wd,
                                input logic r, input logic [3:0] ra);
    cWr = w; cWAddr = wa; cWData = wd; cWBe = 2'b11; cRd = r; cRAddr = ra;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(0, 4'd0, 16'h0, 2'b00, 0, 4'd0, 0);
  endtask

  // scoreboard: every r_valid pulse pops one expected word
  always @(negedge clk) begin
    if (!rst) begin
      if (rValidA) begin
        if (qA.size() == 0) checkOutput("A unexpected r_valid", 32'd1, 32'd0);
        else checkOutput("A r_data", {16'h0, rDataA}, {16'h0, qA.pop_front()});
      end
      if (rValidB) begin
        if (qB.size() == 0) checkOutput("B unexpected r_valid", 32'd1, 32'd0);
        else checkOutput("B r_data", {16'h0, rDataB}, {16'h0, qB.pop_front()});
      end
      if (rValidC) begin
        if (qC.size() == 0) checkOutput("C unexpected r_valid", 32'd1, 32'd0);
        else checkOutput("C r_data", {16'h0, rDataC}, {16'h0, qC.pop_front()});
      end
    end
  end

  initial begin
    int n;
    #1 rst = 1'b1;
    @(negedge clk);
    checkOutput("reset busyA", {31'h0, busyA}, 32'd1);
    checkOutput("reset busyB", {31'h0, busyB}, 32'd1);
    checkOutput("reset busyC", {31'h0, busyC}, 32'd0);
    checkOutput("reset rValidA", {31'h0, rValidA}, 32'd0);
    checkOutput("reset rDataA", {16'h0, rDataA}, 32'd0);
    checkOutput("reset rValidB", {31'h0, rValidB}, 32'd0);
    checkOutput("reset rDataB", {16'h0, rDataB}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] reset clear length");
    n = 0;
    while ((busyA === 1'b1) && (n < 100)) begin @(negedge clk); n++; end
    checkOutput("reset clear cycles", n, 32'd16);
    checkOutput("reset clear busyB", {31'h0, busyB}, 32'd0);

    $display("[TB] read all cleared words");
    for (int i = 0; i < 16; i++) begin
      qA.push_back(16'h0000); qB.push_back(16'h0000);
      applyStimulus(0, 4'd0, 16'h0, 2'b00, 1, i[3:0], 0);
    end
    idle(3);

    $display("[TB] byte enables");
    applyStimulus(1, 4'd3, 16'hABCD, 2'b11, 0, 4'd0, 0);
    applyStimulus(1, 4'd3, 16'h1234, 2'b01, 0, 4'd0, 0);
    applyStimulus(1, 4'd3, 16'h9999, 2'b00, 0, 4'd0, 0);
    qA.push_back(16'hAB34); qB.push_back(16'hAB34);
    applyStimulus(0, 4'd0, 16'h0, 2'b00, 1, 4'd3, 0);
    idle(4);
    checkOutput("rDataA hold", {16'h0, rDataA}, 32'h0000AB34);
    checkOutput("rValidA idle", {31'h0, rValidA}, 32'd0);

    $display("[TB] enb low drops requests");
    enb = 1'b0;
    applyStimulus(1, 4'd3, 16'h5555, 2'b11, 1, 4'd3, 0);
    enb = 1'b1;
    qA.push_back(16'hAB34); qB.push_back(16'hAB34);
    applyStimulus(0, 4'd0, 16'h0, 2'b00, 1, 4'd3, 0);
    idle(3);

    $display("[TB] read during write");
    applyStimulus(1, 4'd5, 16'h1111, 2'b11, 0, 4'd0, 0);
    qA.push_back(16'h1111); qB.push_back(16'h2222);
    applyStimulus(1, 4'd5, 16'h2222, 2'b11, 1, 4'd5, 0);
    qA.push_back(16'h2222); qB.push_back(16'h2222);
    applyStimulus(0, 4'd0, 16'h0, 2'b00, 1, 4'd5, 0);
    idle(3);

    $display("[TB] latency and throughput");
    for (int i = 0; i < 8; i++) applyStimulus(1, i[3:0], 16'(i * 16'h0101), 2'b11, 0, 4'd0, 0);
    for (int i = 0; i < 8; i++) begin
      qA.push_back(16'(i * 16'h0101)); qB.push_back(16'(i * 16'h0101));
      applyStimulus(0, 4'd0, 16'h0, 2'b00, 1, i[3:0], 0);
      if (i == 0) begin
        checkOutput("B latency not early", {31'h0, rValidB}, 32'd0);
        checkOutput("A latency 1", {31'h0, rValidA}, 32'd1);
      end else begin
        checkOutput("B r_valid streaming", {31'h0, rValidB}, 32'd1);
      end
    end
    applyStimulus(0, 4'd0, 16'h0, 2'b00, 0, 4'd0, 0);
    checkOutput("B last r_valid", {31'h0, rValidB}, 32'd1);
    applyStimulus(0, 4'd0, 16'h0, 2'b00, 0, 4'd0, 0);
    checkOutput("B r_valid ends", {31'h0, rValidB}, 32'd0);
    idle(2);

    $display("[TB] soft clear collision");
    applyStimulus(1, 4'd2, 16'hFFFF, 2'b11, 1, 4'd3, 1);
    checkOutput("clr busyA rises", {31'h0, busyA}, 32'd1);
    n = 0;
    while ((busyA === 1'b1) && (n < 100)) begin
      applyStimulus(0, 4'd0, 16'h0, 2'b00, 0, 4'd0, (n == 5));
      n++;
    end
    checkOutput("soft clear cycles", n, 32'd16);
    qA.push_back(16'h0000); qB.push_back(16'h0000);
    applyStimulus(0, 4'd0, 16'h0, 2'b00, 1, 4'd2, 0);
    qA.push_back(16'h0000); qB.push_back(16'h0000);
    applyStimulus(0, 4'd0, 16'h0, 2'b00, 1, 4'd7, 0);
    idle(3);

    $display("[TB] reset mid-clear");
    applyStimulus(1, 4'd15, 16'h7777, 2'b11, 0, 4'd0, 0);
    qA.push_back(16'h7777); qB.push_back(16'h7777);
    applyStimulus(0, 4'd0, 16'h0, 2'b00, 1, 4'd15, 0);
    idle(3);
    applyStimulus(0, 4'd0, 16'h0, 2'b00, 0, 4'd0, 1);
    idle(7);
    rst = 1'b1;
    #1;
    checkOutput("mid rst rValidA", {31'h0, rValidA}, 32'd0);
    checkOutput("mid rst busyA", {31'h0, busyA}, 32'd1);
    checkOutput("mid rst busyB", {31'h0, busyB}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    while ((busyA === 1'b1) && (n < 100)) begin @(negedge clk); n++; end
    checkOutput("restart clear cycles", n, 32'd16);
    qA.push_back(16'h0000); qB.push_back(16'h0000);
    applyStimulus(0, 4'd0, 16'h0, 2'b00, 1, 4'd15, 0);
    qA.push_back(16'h0000); qB.push_back(16'h0000);
    applyStimulus(0, 4'd0, 16'h0, 2'b00, 1, 4'd0, 0);
    idle(3);

    $display("[TB] out-of-range with DEPTH 12");
    checkOutput("C busy after reset", {31'h0, busyC}, 32'd0);
    applyStimulusC(1, 4'd13, 16'hBEEF, 0, 4'd0);
    applyStimulusC(1, 4'd12, 16'hCAFE, 0, 4'd0);
    applyStimulusC(1, 4'd11, 16'h1357, 0, 4'd0);
    qC.push_back(16'h0000);
    applyStimulusC(0, 4'd0, 16'h0, 1, 4'd13);
    qC.push_back(16'h0000);
    applyStimulusC(0, 4'd0, 16'h0, 1, 4'd12);
    qC.push_back(16'h1357);
    applyStimulusC(0, 4'd0, 16'h0, 1, 4'd11);
    applyStimulusC(0, 4'd0, 16'h0, 0, 4'd0);
    applyStimulusC(0, 4'd0, 16'h0, 0, 4'd0);
    applyStimulusC(0, 4'd0, 16'h0, 0, 4'd0);

    checkOutput("A scoreboard drained", qA.size(), 32'd0);
    checkOutput("B scoreboard drained", qB.size(), 32'd0);
    checkOutput("C scoreboard drained", qC.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
